// File: rtl/hpm_tree_detector_if.sv
// Bus between the HPM bank / config master and the tree detector.
// The master drives counters, start and node-table writes; the slave returns status.
interface hpm_tree_detector_if #(
  parameter int NUM_HPM = 4,
  parameter int HPM_W   = 64,
  parameter int DEPTH   = 3,
  parameter int CLASS_W = 2
);
  localparam int NUM_NODES = (1 << DEPTH) - 1;
  localparam int ADDR_W    = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam int SEL_W     = $clog2(NUM_HPM);

  logic [NUM_HPM*HPM_W-1:0] hpm;
  logic                     start;
  logic                     busy;
  logic                     done;
  logic [CLASS_W-1:0]       alert;
  logic [31:0]              attack_count;
  logic                     clr_count;
  logic                     cfg_we;
  logic [ADDR_W-1:0]        cfg_addr;
  logic [SEL_W-1:0]         cfg_sel;
  logic [HPM_W-1:0]         cfg_thr;
  logic                     cfg_leaf;
  logic [CLASS_W-1:0]       cfg_class;
  logic                     cfg_ready;

  modport master (
    output hpm, start, clr_count, cfg_we, cfg_addr, cfg_sel, cfg_thr, cfg_leaf, cfg_class,
    input  busy, done, alert, attack_count, cfg_ready
  );

  modport slave (
    input  hpm, start, clr_count, cfg_we, cfg_addr, cfg_sel, cfg_thr, cfg_leaf, cfg_class,
    output busy, done, alert, attack_count, cfg_ready
  );
endinterface

// File: rtl/hpm_tree_detector.sv
// Classifies an HPM snapshot by walking a programmable decision tree, one node per clock.
// Optional DIWALL_HPM_DELTA_EN: features become counter growth since the previous snapshot.
module hpm_tree_detector #(
  parameter int NUM_HPM = 4,
  parameter int HPM_W   = 64,
  parameter int DEPTH   = 3,
  parameter int CLASS_W = 2
) (
  input logic               clk_h,
  input logic               rst_h,
  hpm_tree_detector_if.slave bus
);
  localparam int NUM_NODES = (1 << DEPTH) - 1;
  localparam int ADDR_W    = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam int SEL_W     = $clog2(NUM_HPM);

  typedef enum logic {IDLE = 1'b0, WALK = 1'b1} state_e;

  state_e                   state_q;
  logic [ADDR_W-1:0]        node_q;
  logic [ADDR_W-1:0]        depth_q;
  logic [NUM_HPM*HPM_W-1:0] snap_q;
`ifdef DIWALL_HPM_DELTA_EN
  logic [NUM_HPM*HPM_W-1:0] prev_q;
`endif
  logic                     done_q;
  logic [CLASS_W-1:0]       alert_q;
  logic [31:0]              count_q;

  logic [SEL_W-1:0]   sel_q   [NUM_NODES];
  logic [HPM_W-1:0]   thr_q   [NUM_NODES];
  logic               leaf_q  [NUM_NODES];
  logic [CLASS_W-1:0] class_q [NUM_NODES];

  logic [HPM_W-1:0]  feat_d;
  logic [ADDR_W-1:0] node_d;
  logic              resolve_d;
  logic              attack_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    feat_d = '0;
    // A selector with no matching counter leaves the feature at 0.
    for (int k = 0; k < NUM_HPM; k++) begin
      if (sel_q[node_q] == SEL_W'(k)) begin
`ifdef DIWALL_HPM_DELTA_EN
        feat_d = snap_q[k*HPM_W +: HPM_W] - prev_q[k*HPM_W +: HPM_W];
`else
        feat_d = snap_q[k*HPM_W +: HPM_W];
`endif
      end
    end
    resolve_d = leaf_q[node_q] || (depth_q == ADDR_W'(DEPTH - 1));
    attack_d  = resolve_d && (class_q[node_q] != '0);
    node_d    = (node_q << 1) + ((feat_d <= thr_q[node_q]) ? ADDR_W'(1) : ADDR_W'(2));
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_h or negedge rst_h) begin
    if (!rst_h) begin
      state_q <= IDLE;
      node_q  <= '0;
      depth_q <= '0;
      snap_q  <= '0;
`ifdef DIWALL_HPM_DELTA_EN
      prev_q  <= '0;
`endif
      done_q  <= 1'b0;
      alert_q <= '0;
      count_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            snap_q  <= bus.hpm;
`ifdef DIWALL_HPM_DELTA_EN
            prev_q  <= snap_q;
`endif
            node_q  <= '0;
            depth_q <= '0;
            state_q <= WALK;
          end
        end
        WALK: begin
          if (resolve_d) begin
            alert_q <= class_q[node_q];
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            node_q  <= node_d;
            depth_q <= depth_q + ADDR_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase

      // Clear beats a simultaneous increment; the count sticks at all-ones.
      if (bus.clr_count) begin
        count_q <= '0;
      end else if ((state_q == WALK) && attack_d && (count_q != '1)) begin
        count_q <= count_q + 32'd1;
      end
    end
  end

  // NOTE: the node table is reset explicitly because an unprogrammed tree must classify as 0.
  always_ff @(posedge clk_h or negedge rst_h) begin
    if (!rst_h) begin
      for (int i = 0; i < NUM_NODES; i++) begin
        sel_q[i]   <= '0;
        thr_q[i]   <= '0;
        leaf_q[i]  <= 1'b1;
        class_q[i] <= '0;
      end
    end else if (bus.cfg_we && (state_q == IDLE) && (bus.cfg_addr < ADDR_W'(NUM_NODES))) begin
      sel_q[bus.cfg_addr]   <= bus.cfg_sel;
      thr_q[bus.cfg_addr]   <= bus.cfg_thr;
      leaf_q[bus.cfg_addr]  <= bus.cfg_leaf;
      class_q[bus.cfg_addr] <= bus.cfg_class;
    end
  end

  assign bus.busy         = (state_q == WALK);
  assign bus.cfg_ready    = (state_q == IDLE);
  assign bus.done         = done_q;
  assign bus.alert        = alert_q;
  assign bus.attack_count = count_q;
endmodule

// File: tb/tb_hpm_tree_detector.sv
// Randomized and directed bench for hpm_tree_detector against a transaction-level tree model.
// Follows DIWALL_HPM_DELTA_EN the same way as the design.
module tb_hpm_tree_detector;
  localparam int NUM_HPM   = 4;
  localparam int HPM_W     = 64;
  localparam int DEPTH     = 3;
  localparam int CLASS_W   = 2;
  localparam int NUM_NODES = 7;

  logic clk_h = 1'b0;
  logic rst_h = 1'b0;
  always #5 clk_h = ~clk_h;

  hpm_tree_detector_if #(.NUM_HPM(NUM_HPM), .HPM_W(HPM_W), .DEPTH(DEPTH), .CLASS_W(CLASS_W)) bus ();

  hpm_tree_detector #(.NUM_HPM(NUM_HPM), .HPM_W(HPM_W), .DEPTH(DEPTH), .CLASS_W(CLASS_W)) dut (
    .clk_h (clk_h),
    .rst_h (rst_h),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: node table, snapshots and an event timeline for the current walk.
  logic [HPM_W-1:0] m_snap [NUM_HPM];
  logic [HPM_W-1:0] m_prev [NUM_HPM];
  int               m_sel  [NUM_NODES];
  logic [HPM_W-1:0] m_thr  [NUM_NODES];
  bit               m_leaf [NUM_NODES];
  int               m_cls  [NUM_NODES];
  bit               m_walking = 1'b0;
  longint           cyc = 0;
  longint           m_end = 0;
  int               m_pend_cls = 0;
  bit               e_done = 1'b0;
  int               e_alert = 0;
  logic [31:0]      e_count = '0;
  int               preload_seq = 0;
  int               preload_seen = 0;
  logic [31:0]      preload_val = '0;

  function automatic logic [HPM_W-1:0] feature(input int k);
    if (k >= NUM_HPM) return '0;
`ifdef DIWALL_HPM_DELTA_EN
    return m_snap[k] - m_prev[k];
`else
    return m_snap[k];
`endif
  endfunction

  function automatic void model_walk(output int cls, output int depth);
    int n = 0;
    int d = 0;
    while (!(m_leaf[n] || d == DEPTH - 1)) begin
      n = (feature(m_sel[n]) <= m_thr[n]) ? 2 * n + 1 : 2 * n + 2;
      d++;
    end
    cls   = m_cls[n];
    depth = d;
  endfunction

  always @(posedge clk_h or negedge rst_h) begin
    int cls;
    int d;
    if (!rst_h) begin
      m_walking = 1'b0;
      e_done    = 1'b0;
      e_alert   = 0;
      e_count   = '0;
      for (int i = 0; i < NUM_NODES; i++) begin
        m_sel[i] = 0; m_thr[i] = '0; m_leaf[i] = 1'b1; m_cls[i] = 0;
      end
      for (int k = 0; k < NUM_HPM; k++) begin
        m_snap[k] = '0; m_prev[k] = '0;
      end
    end else begin
      cyc++;
      if (preload_seq != preload_seen) begin
        e_count      = preload_val;
        preload_seen = preload_seq;
      end
      e_done = 1'b0;
      if (m_walking && cyc == m_end) begin
        e_done    = 1'b1;
        e_alert   = m_pend_cls;
        m_walking = 1'b0;
        if (bus.clr_count) e_count = '0;
        else if (m_pend_cls != 0 && e_count != 32'hFFFF_FFFF) e_count = e_count + 1;
      end else begin
        if (bus.clr_count) e_count = '0;
        if (!m_walking) begin
          if (bus.cfg_we && int'(bus.cfg_addr) < NUM_NODES) begin
            m_sel[bus.cfg_addr]  = int'(bus.cfg_sel);
            m_thr[bus.cfg_addr]  = bus.cfg_thr;
            m_leaf[bus.cfg_addr] = bus.cfg_leaf;
            m_cls[bus.cfg_addr]  = int'(bus.cfg_class);
          end
          if (bus.start) begin
            for (int k = 0; k < NUM_HPM; k++) begin
              m_prev[k] = m_snap[k];
              m_snap[k] = bus.hpm[k*HPM_W +: HPM_W];
            end
            model_walk(cls, d);
            m_end      = cyc + 1 + d;
            m_pend_cls = cls;
            m_walking  = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk_h) begin
    check("busy", {63'd0, bus.busy}, {63'd0, m_walking});
    check("cfg_ready", {63'd0, bus.cfg_ready}, {63'd0, !m_walking});
    check("done", {63'd0, bus.done}, {63'd0, e_done});
    check("alert", 64'(bus.alert), 64'(e_alert));
    check("attack_count", 64'(bus.attack_count), 64'(e_count));
  end

  task automatic tick();
    @(posedge clk_h);
    #2;
  endtask

  task automatic set_hpm(input logic [63:0] h0, input logic [63:0] h1,
                         input logic [63:0] h2, input logic [63:0] h3);
    bus.hpm = {h3, h2, h1, h0};
  endtask

  task automatic wr_node(input int addr, input int sel, input logic [63:0] thr,
                         input bit leaf, input int cls);
    bus.cfg_addr  = 3'(addr);
    bus.cfg_sel   = 2'(sel);
    bus.cfg_thr   = thr;
    bus.cfg_leaf  = leaf;
    bus.cfg_class = 2'(cls);
    bus.cfg_we    = 1'b1;
    tick();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic run_walk(input string name, input int exp_cls, input int exp_lat, input bit clr);
    int n = 0;
    bus.clr_count = clr;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    while (!bus.done && n < 20) begin
      tick();
      n++;
    end
    bus.clr_count = 1'b0;
    check({name, " latency"}, 64'(n), 64'(exp_lat));
    check({name, " alert"}, 64'(bus.alert), 64'(exp_cls));
  endtask

  task automatic preload(input logic [31:0] v);
    @(negedge clk_h);
    #1;
    force dut.count_q = v;
    preload_val = v;
    preload_seq++;
    #1;
    release dut.count_q;
    tick();
  endtask

  initial begin
    bus.hpm = '0; bus.start = 1'b0; bus.clr_count = 1'b0; bus.cfg_we = 1'b0;
    bus.cfg_addr = '0; bus.cfg_sel = '0; bus.cfg_thr = '0; bus.cfg_leaf = 1'b0; bus.cfg_class = '0;
    repeat (3) tick();
    rst_h = 1'b1;
    tick();

    set_hpm(64'd0, 64'd0, 64'd0, 64'd0);
    run_walk("reset_root", 0, 1, 1'b0);
    check("reset_root count", 64'(bus.attack_count), 64'd0);

`ifndef DIWALL_HPM_DELTA_EN
    wr_node(0, 0, 64'd55, 1'b0, 0);
    wr_node(1, 0, 64'd0, 1'b1, 0);
    wr_node(2, 1, 64'd595, 1'b0, 0);
    wr_node(5, 0, 64'd0, 1'b1, 2);
    wr_node(6, 0, 64'd0, 1'b1, 3);
    set_hpm(64'd40, 64'd0, 64'd0, 64'd0);
    run_walk("legit", 0, 2, 1'b0);
    set_hpm(64'd60, 64'd500, 64'd0, 64'd0);
    run_walk("class2", 2, 3, 1'b0);
    set_hpm(64'd60, 64'd600, 64'd0, 64'd0);
    run_walk("class3", 3, 3, 1'b0);
    check("count after two attacks", 64'(bus.attack_count), 64'd2);

    // Table write attempted while walking must be dropped.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wr_node(0, 0, 64'd0, 1'b1, 3);
    repeat (4) tick();
    set_hpm(64'd40, 64'd0, 64'd0, 64'd0);
    run_walk("cfg_during_walk", 0, 2, 1'b0);

    preload(32'hFFFF_FFFE);
    set_hpm(64'd60, 64'd600, 64'd0, 64'd0);
    run_walk("sat_a", 3, 3, 1'b0);
    check("count reaches max", 64'(bus.attack_count), 64'hFFFF_FFFF);
    run_walk("sat_b", 3, 3, 1'b0);
    check("count saturates", 64'(bus.attack_count), 64'hFFFF_FFFF);
    run_walk("clr_wins", 3, 3, 1'b1);
    check("clr beats increment", 64'(bus.attack_count), 64'd0);
`else
    wr_node(0, 0, 64'd55, 1'b0, 0);
    wr_node(1, 0, 64'd0, 1'b1, 1);
    wr_node(2, 0, 64'd0, 1'b1, 2);
    set_hpm(64'd100, 64'd0, 64'd0, 64'd0);
    run_walk("delta_first", 2, 2, 1'b0);
    set_hpm(64'd130, 64'd0, 64'd0, 64'd0);
    run_walk("delta_30", 1, 2, 1'b0);
    set_hpm(64'hFFFF_FFFF_FFFF_FFF6, 64'd0, 64'd0, 64'd0);
    run_walk("delta_big", 2, 2, 1'b0);
    set_hpm(64'd20, 64'd0, 64'd0, 64'd0);
    run_walk("delta_wrap", 1, 2, 1'b0);
`endif

    // Reset in the second WALK cycle of a full-depth walk.
    wr_node(0, 0, 64'd0, 1'b0, 0);
    wr_node(2, 1, 64'd0, 1'b0, 0);
    wr_node(6, 0, 64'd0, 1'b1, 3);
    set_hpm(64'd1000, 64'd1000, 64'd0, 64'd0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    rst_h = 1'b0;
    #1;
    check("midreset busy", {63'd0, bus.busy}, 64'd0);
    check("midreset done", {63'd0, bus.done}, 64'd0);
    check("midreset alert", 64'(bus.alert), 64'd0);
    tick();
    rst_h = 1'b1;
    tick();
    run_walk("post_reset_root", 0, 1, 1'b0);

    // Random traffic: starts, writes (including during walks and to the unused address), clears.
    for (int i = 0; i < 3000; i++) begin
      bus.start     = ($urandom_range(0, 2) == 0);
      bus.clr_count = ($urandom_range(0, 31) == 0);
      bus.cfg_we    = ($urandom_range(0, 3) == 0);
      bus.cfg_addr  = 3'($urandom_range(0, 7));
      bus.cfg_sel   = 2'($urandom_range(0, 3));
      bus.cfg_thr   = 64'($urandom_range(0, 1023));
      bus.cfg_leaf  = ($urandom_range(0, 3) == 0);
      bus.cfg_class = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0)
        set_hpm({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
      else
        set_hpm(64'($urandom_range(0, 1023)), 64'($urandom_range(0, 1023)),
                64'($urandom_range(0, 1023)), 64'($urandom_range(0, 1023)));
      tick();
    end
    bus.start = 1'b0; bus.cfg_we = 1'b0; bus.clr_count = 1'b0;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
